// File: rtl/cache_arbiter_pkg.sv
// Shared types and constants for the two-port cache arbiter.
// State encoding, port indices and default cache latencies live here.
package cache_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int FETCH = 0;
    localparam int DATA  = 1;

    localparam int DEF_HIT_LAT  = 3;
    localparam int DEF_MISS_LAT = 16;
    localparam int CNT_W        = 5;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter with a one-hot grant.
// On contention the port that was not served last wins.
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] gnt
);

    assign gnt[0] = req[0] & (~req[1] | last);
    assign gnt[1] = req[1] & (~req[0] | ~last);

endmodule

// File: rtl/cache_arbiter.sv
// Arbitrates a fetch port and a data port onto one cache interface.
// Tracks hit/miss latency with a cycle counter and keeps saturating statistics.
module cache_arbiter
    import cache_arbiter_pkg::*;
#(
    parameter int D_WIDTH  = 8,
    parameter int A_WIDTH  = 8,
    parameter int HIT_LAT  = DEF_HIT_LAT,
    parameter int MISS_LAT = DEF_MISS_LAT
) (
    input  logic               clk,
    input  logic               clr,
    input  logic               req_0,
    input  logic               rw_0,
    input  logic [A_WIDTH-1:0] addr_0,
    input  logic [D_WIDTH-1:0] wdata_0,
    output logic               gnt_0,
    output logic               done_0,
    input  logic               req_1,
    input  logic               rw_1,
    input  logic [A_WIDTH-1:0] addr_1,
    input  logic [D_WIDTH-1:0] wdata_1,
    output logic               gnt_1,
    output logic               done_1,
    output logic [D_WIDTH-1:0] rdata,
    output logic               hit_flag,
    output logic               c_enab,
    output logic               c_rw,
    output logic [A_WIDTH-1:0] c_addr,
    output logic [D_WIDTH-1:0] c_wdata,
    input  logic [D_WIDTH-1:0] c_rdata,
    input  logic               c_hit,
    output logic [7:0]         hit_cnt,
    output logic [7:0]         miss_cnt
);

    localparam logic [CNT_W-1:0] HIT_LAST  = CNT_W'(HIT_LAT - 1);
    localparam logic [CNT_W-1:0] MISS_LAST = CNT_W'(MISS_LAT - 1);

    state_t             state, next_state;
    logic [1:0]         arb_gnt;
    logic               last_q;
    logic               win_q;
    logic               miss_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               rw_q;
    logic [A_WIDTH-1:0] addr_q;
    logic [D_WIDTH-1:0] wdata_q;
    logic               load;
    logic               finish;
    logic               miss_set;

    rr_arb2 u_arb (
        .req  ({req_1, req_0}),
        .last (last_q),
        .gnt  (arb_gnt)
    );

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // A miss is recorded at the hit-sampling point and then waits out the full miss latency.
    always_comb begin
        next_state = state;
        load       = 1'b0;
        finish     = 1'b0;
        miss_set   = 1'b0;
        case (state)
            IDLE: begin
                if (|arb_gnt) begin
                    load       = 1'b1;
                    next_state = BUSY;
                end
            end
            BUSY: begin
                if (cnt_q == HIT_LAST && !miss_q) begin
                    if (c_hit) begin
                        finish     = 1'b1;
                        next_state = DONE;
                    end else begin
                        miss_set = 1'b1;
                    end
                end else if (cnt_q == MISS_LAST && miss_q) begin
                    finish     = 1'b1;
                    next_state = DONE;
                end
            end
            DONE: begin
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Results are captured on entry to DONE so they are valid alongside the done pulse.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            last_q   <= 1'b1;
            win_q    <= 1'b0;
            miss_q   <= 1'b0;
            cnt_q    <= '0;
            rw_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata    <= '0;
            hit_flag <= 1'b0;
            hit_cnt  <= '0;
            miss_cnt <= '0;
        end else begin
            if (load) begin
                win_q   <= arb_gnt[DATA];
                rw_q    <= arb_gnt[DATA] ? rw_1    : rw_0;
                addr_q  <= arb_gnt[DATA] ? addr_1  : addr_0;
                wdata_q <= arb_gnt[DATA] ? wdata_1 : wdata_0;
                cnt_q   <= '0;
                miss_q  <= 1'b0;
            end else if (state == BUSY) begin
                cnt_q <= cnt_q + 1'b1;
                if (miss_set) begin
                    miss_q <= 1'b1;
                end
            end
            if (finish) begin
                hit_flag <= ~miss_q;
                if (!rw_q) begin
                    rdata <= c_rdata;
                end
                if (miss_q) begin
                    if (miss_cnt != 8'hFF) begin
                        miss_cnt <= miss_cnt + 8'd1;
                    end
                end else if (hit_cnt != 8'hFF) begin
                    hit_cnt <= hit_cnt + 8'd1;
                end
            end
            if (state == DONE) begin
                last_q <= win_q;
            end
        end
    end

    // Grants are gated by reset so a held request cannot show a grant while clr is low.
    assign gnt_0   = clr & (state == IDLE) & arb_gnt[FETCH];
    assign gnt_1   = clr & (state == IDLE) & arb_gnt[DATA];
    assign done_0  = (state == DONE) & ~win_q;
    assign done_1  = (state == DONE) & win_q;
    assign c_enab  = (state == BUSY);
    assign c_rw    = rw_q;
    assign c_addr  = addr_q;
    assign c_wdata = wdata_q;

endmodule

// File: tb/tb_cache_arbiter.sv
// Directed testbench for cache_arbiter with a scoreboard of expected completions.
// The bench acts as both requesters and as the cache, returning a fixed hit/rdata per request.
module tb_cache_arbiter;

    typedef struct {
        logic       port;
        logic       rw;
        logic [7:0] addr;
        logic [7:0] wdata;
        logic       hit;
        logic [7:0] rdata;
        logic [7:0] hits;
        logic [7:0] misses;
    } exp_t;

    logic       clk = 1'b0;
    logic       clr;
    logic       req_0, rw_0, req_1, rw_1;
    logic [7:0] addr_0, wdata_0, addr_1, wdata_1;
    logic       gnt_0, done_0, gnt_1, done_1;
    logic [7:0] rdata;
    logic       hit_flag;
    logic       c_enab, c_rw;
    logic [7:0] c_addr, c_wdata, c_rdata;
    logic       c_hit;
    logic [7:0] hit_cnt, miss_cnt;

    int   checks = 0;
    int   passes = 0;
    int   fails  = 0;
    exp_t sb[$];
    logic [7:0] m_rdata, m_hits, m_misses;

    cache_arbiter dut (
        .clk      (clk),
        .clr      (clr),
        .req_0    (req_0),
        .rw_0     (rw_0),
        .addr_0   (addr_0),
        .wdata_0  (wdata_0),
        .gnt_0    (gnt_0),
        .done_0   (done_0),
        .req_1    (req_1),
        .rw_1     (rw_1),
        .addr_1   (addr_1),
        .wdata_1  (wdata_1),
        .gnt_1    (gnt_1),
        .done_1   (done_1),
        .rdata    (rdata),
        .hit_flag (hit_flag),
        .c_enab   (c_enab),
        .c_rw     (c_rw),
        .c_addr   (c_addr),
        .c_wdata  (c_wdata),
        .c_rdata  (c_rdata),
        .c_hit    (c_hit),
        .hit_cnt  (hit_cnt),
        .miss_cnt (miss_cnt)
    );

    always #5 clk = ~clk;

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) passes++;
        else begin
            fails++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic checkResetState(input string tag);
        checkVal({tag, " gnt/done/enab"}, 32'({gnt_0, gnt_1, done_0, done_1, c_enab}), 32'd0);
        checkVal({tag, " cache bus"}, 32'({c_rw, c_addr, c_wdata}), 32'd0);
        checkVal({tag, " rdata"}, 32'(rdata), 32'd0);
        checkVal({tag, " hit_flag"}, 32'(hit_flag), 32'd0);
        checkVal({tag, " hit_cnt"}, 32'(hit_cnt), 32'd0);
        checkVal({tag, " miss_cnt"}, 32'(miss_cnt), 32'd0);
    endtask

    task automatic resetDut();
        clr = 1'b0;
        req_0 = 1'b0; rw_0 = 1'b0; addr_0 = 8'h00; wdata_0 = 8'h00;
        req_1 = 1'b0; rw_1 = 1'b0; addr_1 = 8'h00; wdata_1 = 8'h00;
        c_hit = 1'b0; c_rdata = 8'h00;
        m_rdata = 8'h00; m_hits = 8'h00; m_misses = 8'h00;
        sb.delete();
        repeat (2) @(negedge clk);
        checkResetState("reset");
        clr = 1'b1;
        @(negedge clk);
    endtask

    // Raise a request and, if it is expected to complete, queue its predicted result.
    task automatic applyStimulus(input logic port, input logic rw, input logic [7:0] addr,
                                 input logic [7:0] wdata, input logic hit,
                                 input logic [7:0] crdata, input bit push);
        exp_t e;
        c_hit   = hit;
        c_rdata = crdata;
        if (port) begin
            req_1 = 1'b1; rw_1 = rw; addr_1 = addr; wdata_1 = wdata;
        end else begin
            req_0 = 1'b1; rw_0 = rw; addr_0 = addr; wdata_0 = wdata;
        end
        if (push) begin
            if (!rw) m_rdata = crdata;
            if (hit) m_hits = (m_hits == 8'hFF) ? 8'hFF : m_hits + 8'd1;
            else     m_misses = (m_misses == 8'hFF) ? 8'hFF : m_misses + 8'd1;
            e = '{port, rw, addr, wdata, hit, m_rdata, m_hits, m_misses};
            sb.push_back(e);
        end
    endtask

    task automatic checkOutput(input int exp_lat, input int exp_enab);
        exp_t e;
        int   lat  = 0;
        int   enab = 0;
        bit   bad  = 1'b0;
        bit   excl = 1'b0;
        bit   seen = 1'b0;
        for (int i = 1; i <= 60; i++) begin
            @(negedge clk);
            if ((gnt_0 && gnt_1) || (done_0 && done_1)) excl = 1'b1;
            if (c_enab) begin
                enab++;
                if (sb.size() > 0) begin
                    if (c_addr !== sb[0].addr || c_wdata !== sb[0].wdata || c_rw !== sb[0].rw)
                        bad = 1'b1;
                end
            end
            if (done_0 || done_1) begin
                lat  = i;
                seen = 1'b1;
                break;
            end
        end
        checkVal("done seen", 32'(seen), 32'd1);
        checkVal("scoreboard nonempty", 32'(sb.size() != 0), 32'd1);
        if (sb.size() == 0) return;
        e = sb.pop_front();
        if (seen) begin
            checkVal("done port", 32'({done_1, done_0}), e.port ? 32'd2 : 32'd1);
            checkVal("hit_flag", 32'(hit_flag), 32'(e.hit));
            checkVal("rdata", 32'(rdata), 32'(e.rdata));
            checkVal("hit_cnt", 32'(hit_cnt), 32'(e.hits));
            checkVal("miss_cnt", 32'(miss_cnt), 32'(e.misses));
            checkVal("c_enab low in done", 32'(c_enab), 32'd0);
            if (done_0) req_0 = 1'b0;
            if (done_1) req_1 = 1'b0;
        end
        checkVal("cache bus stable", 32'(bad), 32'd0);
        checkVal("gnt/done exclusive", 32'(excl), 32'd0);
        if (exp_lat >= 0) checkVal("done latency", 32'(lat), 32'(exp_lat));
        if (exp_enab >= 0) checkVal("c_enab cycles", 32'(enab), 32'(exp_enab));
    endtask

    initial begin
        bit done_seen;

        resetDut();

        $display("[TB] single read hit on fetch port");
        applyStimulus(1'b0, 1'b0, 8'h12, 8'h00, 1'b1, 8'hA5, 1'b1);
        #1;
        checkVal("gnt_0 at grant", 32'(gnt_0), 32'd1);
        checkVal("gnt_1 at grant", 32'(gnt_1), 32'd0);
        checkOutput(4, 3);
        @(negedge clk);

        $display("[TB] write miss on data port");
        applyStimulus(1'b1, 1'b1, 8'h05, 8'h3C, 1'b0, 8'h99, 1'b1);
        checkOutput(17, 16);
        @(negedge clk);

        $display("[TB] requester inputs change mid-transaction");
        applyStimulus(1'b1, 1'b0, 8'h40, 8'h00, 1'b0, 8'h5A, 1'b1);
        repeat (4) @(negedge clk);
        addr_1 = 8'hEE;
        req_1  = 1'b0;
        checkOutput(-1, -1);
        @(negedge clk);

        applyStimulus(1'b0, 1'b0, 8'h21, 8'h00, 1'b1, 8'hC3, 1'b1);
        checkOutput(4, 3);
        @(negedge clk);

        $display("[TB] reset during a miss");
        applyStimulus(1'b1, 1'b0, 8'h77, 8'h00, 1'b0, 8'h11, 1'b0);
        done_seen = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            if (done_0 || done_1) done_seen = 1'b1;
        end
        checkVal("busy before reset", 32'(c_enab), 32'd1);
        clr = 1'b0;
        #1;
        checkResetState("mid-miss reset");
        repeat (2) begin
            @(negedge clk);
            if (done_0 || done_1) done_seen = 1'b1;
        end
        req_1 = 1'b0;
        clr   = 1'b1;
        m_rdata = 8'h00; m_hits = 8'h00; m_misses = 8'h00;
        repeat (2) begin
            @(negedge clk);
            if (done_0 || done_1) done_seen = 1'b1;
        end
        checkVal("no done after abort", 32'(done_seen), 32'd0);

        $display("[TB] contention alternates starting with fetch port");
        applyStimulus(1'b0, 1'b0, 8'h30, 8'h00, 1'b1, 8'h66, 1'b1);
        applyStimulus(1'b1, 1'b0, 8'h31, 8'h00, 1'b1, 8'h66, 1'b1);
        #1;
        checkVal("contention gnt_0", 32'(gnt_0), 32'd1);
        checkVal("contention gnt_1", 32'(gnt_1), 32'd0);
        checkOutput(4, 3);
        applyStimulus(1'b0, 1'b0, 8'h32, 8'h00, 1'b1, 8'h66, 1'b1);
        checkOutput(-1, 3);
        applyStimulus(1'b1, 1'b0, 8'h33, 8'h00, 1'b1, 8'h66, 1'b1);
        checkOutput(-1, 3);
        checkOutput(-1, 3);

        $display("[TB] hit counter saturation");
        resetDut();
        for (int k = 0; k < 300; k++) begin
            applyStimulus(1'b0, 1'b0, 8'(k), 8'h00, 1'b1, 8'(k * 7), 1'b1);
            checkOutput(-1, 3);
        end
        checkVal("saturated hit_cnt", 32'(hit_cnt), 32'hFF);
        checkVal("saturated miss_cnt", 32'(miss_cnt), 32'd0);

        $display("[TB] %0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/cache_arbiter.md
CACHE_ARBITER -- requirements
Module: cache_arbiter

Interface
REQ-001 Parameter D_WIDTH, default 8, data width.
REQ-002 Parameter A_WIDTH, default 8, address width.
REQ-003 Parameter HIT_LAT, default 3, cycles from cache enable to hit-result sampling.
REQ-004 Parameter MISS_LAT, default 16, cycles from cache enable to miss completion; SHALL exceed HIT_LAT.
REQ-005 The block SHALL have one clock; reset is asynchronous and active-low; ports:
- clk  in  1  single clock, rising edge.
- clr  in  1  asynchronous active-low reset.
REQ-006 Requester ports, with r in {0 = fetch, 1 = data}:
- req_r  in  1  request, held until done_r.
- rw_r  in  1  0 read, 1 write.
- addr_r  in  A_WIDTH  target address.
- wdata_r  in  D_WIDTH  write data.
- gnt_r  out  1  one-cycle grant pulse.
- done_r  out  1  one-cycle completion pulse.
REQ-007 Shared outputs:
- rdata  out  D_WIDTH  read data, valid with done_r.
- hit_flag  out  1  hit/miss result, valid with done_r.
REQ-008 Cache-side ports:
- c_enab  out  1  cache enable.
- c_rw  out  1  cache read/write.
- c_addr  out  A_WIDTH  cache address.
- c_wdata  out  D_WIDTH  cache write data.
- c_rdata  in  D_WIDTH  cache read data.
- c_hit  in  1  cache hit flag.
REQ-009 Statistics outputs:
- hit_cnt  out  8  saturating hit counter.
- miss_cnt  out  8  saturating miss counter.

Function
REQ-010 FSM states: IDLE, BUSY, DONE; encoding per shared package.
REQ-011 In IDLE with no req_r asserted, the FSM SHALL stay in IDLE.
REQ-012 In IDLE with at least one req_r, the FSM SHALL select a winner, latch its rw/addr/wdata into internal registers, pulse that port's gnt_r, clear the cycle counter, and go to BUSY.
REQ-013 Arbitration SHALL be round-robin: on a simultaneous request, the port not served last wins; after reset, port 0 has priority.
REQ-014 In BUSY, c_enab SHALL be 1 and c_rw/c_addr/c_wdata SHALL drive the latched values, stable for the whole transaction regardless of requester inputs.
REQ-015 The cycle counter (5 bits) SHALL increment every BUSY cycle.
REQ-016 At counter == HIT_LAT-1 the FSM SHALL sample c_hit: if 1, record hit and go to DONE; if 0, record miss and remain in BUSY.
REQ-017 At counter == MISS_LAT-1, with a miss recorded, the FSM SHALL go to DONE.
REQ-018 In DONE, c_enab SHALL be 0 and the FSM SHALL:
- capture c_rdata into rdata for reads only, leaving rdata unchanged on writes;
- drive hit_flag;
- pulse the winner's done_r for exactly one cycle;
- update the last-served pointer;
- return to IDLE.
REQ-019 The minimum spacing between cache transactions SHALL be one cycle with c_enab = 0, which returns the cache sequencer to its initial state.
REQ-020 hit_cnt SHALL increment on each hit and miss_cnt on each miss, both in DONE, and each SHALL saturate at 8'hFF.
REQ-021 A requester dropping req_r mid-transaction SHALL NOT abort the transaction; its done_r still pulses.
REQ-022 gnt_0/gnt_1 SHALL be mutually exclusive, and likewise done_0/done_1.
REQ-023 The same port may be granted back-to-back when the other port is not requesting.

Reset
REQ-024 While clr = 0, asynchronously, the block SHALL set:
- state to IDLE;
- all gnt/done outputs and c_enab to 0;
- c_rw, c_addr, c_wdata, rdata, hit_flag, hit_cnt, miss_cnt and the counter to 0;
- the last-served pointer to port 1.
REQ-025 Reset asserted mid-transaction SHALL abandon the transaction with no done_r pulse.

Structure
REQ-026 A shared package SHALL hold the FSM state typedef, the port-index constants FETCH = 0 and DATA = 1, and the default latencies.
REQ-027 A single sub-module rr_arb2 (2-way round-robin, pointer input, one-hot grant) SHALL be used; all other logic SHALL be flat.

Verification
REQ-028 Single read hit: port 0 reads 8'h12 with c_hit = 1 and c_rdata = 8'hA5 -> gnt_0 at cycle 0, done_0 at cycle 4, rdata = 8'hA5, hit_flag = 1, hit_cnt = 1.
REQ-029 Write miss: port 1 writes 8'h3C to 8'h05 with c_hit = 0 -> c_enab high for 16 cycles with c_addr = 8'h05 and c_wdata = 8'h3C, then done_1, miss_cnt = 1.
REQ-030 Contention after reset: both req asserted together -> port 0 served first, then port 1, then port 0, alternating.
REQ-031 Input instability: addr_1 changes and req_1 drops during BUSY -> c_addr holds the latched value and done_1 still pulses.
REQ-032 Reset mid-miss: clr = 0 at BUSY cycle 7 -> all outputs 0 immediately, no done pulse, and the next request is served by port 0 first.
REQ-033 Saturation: 300 hits -> hit_cnt = 8'hFF and miss_cnt = 0.
